// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_pkg
// Brief    : Shared sizes and FSM state encodings for priority_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package prio_pkg;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;
   localparam int ST_W    = 2;

   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/priority_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : priority_irq_ctrl_if
// Brief    : Request/issue bundle between an interrupt consumer and the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface priority_irq_ctrl_if;
   import prio_pkg::*;

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] mask;
   logic               ack;
   logic               clr_ovr;
   logic               irq_valid;
   logic [ID_W-1:0]    irq_id;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] ovr;

   modport master (
      output req, mask, ack, clr_ovr,
      input  irq_valid, irq_id, pending, ovr
   );

   modport slave (
      input  req, mask, ack, clr_ovr,
      output irq_valid, irq_id, pending, ovr
   );

endinterface
`default_nettype wire

// File: rtl/priority_irq_ctrl_pend_enc8.sv
`default_nettype none
// ============================================================================
// Module   : pend_enc8
// Brief    : Combinational highest-set-index encoder with any-valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module pend_enc8
   import prio_pkg::*;
(
   input  logic [NUM_SRC-1:0] i_vec,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Ascending scan so the highest set bit is the last one written
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (i_vec[i]) begin
            o_idx = ID_W'(i);
         end
      end
   end

   assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/priority_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : priority_irq_ctrl
// Brief    : 8-source priority interrupt controller with pending/overrun tracking.
// Revision : 1.0 - initial release
// ============================================================================
module priority_irq_ctrl
   import prio_pkg::*;
#(
   parameter int EDGE_MODE = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   priority_irq_ctrl_if.slave   bus
);

   logic [NUM_SRC-1:0] r_req_d;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_ovr;
   logic [ID_W-1:0]    r_irq_id;
   logic [ST_W-1:0]    r_state;
   logic [ST_W-1:0]    w_state_nxt;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_ovr_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_cand;
   logic [ID_W-1:0]    w_enc_idx;
   logic               w_enc_any;
   logic               w_ack_hit;
   logic               w_issue;

   generate
      if (EDGE_MODE != 0) begin : g_edge
         assign w_edge    = bus.req & ~r_req_d;
         assign w_ovr_set = w_edge & r_pending;
      end else begin : g_level
         assign w_edge    = bus.req;
         assign w_ovr_set = '0;
      end
   endgenerate

   assign w_cand    = r_pending & bus.mask;
   assign w_ack_hit = (r_state == ST_ISSUE) && bus.ack;
   assign w_clr     = w_ack_hit ? (NUM_SRC'(1) << r_irq_id) : '0;

   pend_enc8 u_enc (
      .i_vec (w_cand),
      .o_idx (w_enc_idx),
      .o_any (w_enc_any)
   );

   // Set terms are OR-ed after the clear terms so a new event always wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_d   <= '0;
         r_pending <= '0;
         r_ovr     <= '0;
         r_irq_id  <= '0;
      end else begin
         r_req_d   <= bus.req;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_ovr     <= (r_ovr & ~{NUM_SRC{bus.clr_ovr}}) | w_ovr_set;
         if ((r_state == ST_IDLE) && w_enc_any) begin
            r_irq_id <= w_enc_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_enc_any) w_state_nxt = ST_ISSUE;
         ST_ISSUE: if (bus.ack)   w_state_nxt = ST_GAP;
         ST_GAP:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_issue = (r_state == ST_ISSUE);
   end

   assign bus.irq_valid = w_issue;
   assign bus.irq_id    = r_irq_id;
   assign bus.pending   = r_pending;
   assign bus.ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_priority_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_irq_ctrl
// Brief    : Scoreboard bench for priority_irq_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_irq_ctrl;

   typedef struct packed {
      logic       v;
      logic [2:0] id;
      logic [7:0] pend;
      logic [7:0] ovr;
   } exp_t;

   logic clk;
   logic rst;
   priority_irq_ctrl_if bus ();

   priority_irq_ctrl #(.EDGE_MODE(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: phase 0 = waiting, 1 = presenting an id, 2 = quiet cycle
   logic [7:0] m_pend, m_ovr, m_prev;
   logic [2:0] m_id;
   int         m_phase;

   function automatic int top_bit(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [7:0] r, m, input logic a, co, rs);
      logic [7:0] ev;
      logic [7:0] clr;
      int         h;
      if (rs) begin
         m_pend = 8'h00; m_ovr = 8'h00; m_prev = 8'h00; m_id = 3'd0; m_phase = 0;
      end else begin
         ev    = r & ~m_prev;
         clr   = (m_phase == 1 && a) ? (8'h01 << m_id) : 8'h00;
         m_ovr = (co ? 8'h00 : m_ovr) | (ev & m_pend);
         h     = top_bit(m_pend & m);
         m_pend = (m_pend & ~clr) | ev;
         case (m_phase)
            0: if (h >= 0) begin m_id = h[2:0]; m_phase = 1; end
            1: if (a) m_phase = 2;
            default: m_phase = 0;
         endcase
         m_prev = r;
      end
   endtask

   task automatic cyc(input logic [7:0] r, m, input logic a, co, rs);
      exp_t e;
      @(negedge clk);
      bus.req = r; bus.mask = m; bus.ack = a; bus.clr_ovr = co; rst = rs;
      model_step(r, m, a, co, rs);
      e.v = (m_phase == 1); e.id = m_id; e.pend = m_pend; e.ovr = m_ovr;
      exp_q.push_back(e);
   endtask

   // Hold inputs until the model is presenting, then acknowledge once
   task automatic hold_then_ack(input logic [7:0] r, m, input int max_cyc);
      int n;
      n = 0;
      while (m_phase != 1 && n < max_cyc) begin
         cyc(r, m, 1'b0, 1'b0, 1'b0);
         n++;
      end
      if (m_phase != 1) begin
         failures++;
         $display("FAIL issue_timeout: no issue within %0d cycles, required one", max_cyc);
      end
      cyc(r, m, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: compare DUT outputs just after each active edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.irq_valid !== e.v) begin
               failures++;
               $display("FAIL irq_valid @%0t: got %b, expected %b", $time, bus.irq_valid, e.v);
            end
            checks++;
            if (bus.irq_id !== e.id) begin
               failures++;
               $display("FAIL irq_id @%0t: got %0d, expected %0d", $time, bus.irq_id, e.id);
            end
            checks++;
            if (bus.pending !== e.pend) begin
               failures++;
               $display("FAIL pending @%0t: got %h, expected %h", $time, bus.pending, e.pend);
            end
            checks++;
            if (bus.ovr !== e.ovr) begin
               failures++;
               $display("FAIL ovr @%0t: got %h, expected %h", $time, bus.ovr, e.ovr);
            end
         end
      end
   end

   initial begin
      logic [7:0] r, m;
      logic       a, co, rs;
      rst = 1'b1; bus.req = 8'h00; bus.mask = 8'hFF; bus.ack = 1'b0; bus.clr_ovr = 1'b0;
      m_pend = 8'h00; m_ovr = 8'h00; m_prev = 8'h00; m_id = 3'd0; m_phase = 0;

      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);

      // Single edge, with a stray ack while idle
      cyc(8'h04, 8'hFF, 1'b1, 1'b0, 1'b0);
      hold_then_ack(8'h00, 8'hFF, 6);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // Two sources rise together
      cyc(8'h81, 8'hFF, 1'b0, 1'b0, 1'b0);
      hold_then_ack(8'h00, 8'hFF, 6);
      hold_then_ack(8'h00, 8'hFF, 6);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // No preemption, then masking
      repeat (4) cyc(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(8'h42, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h42, 8'hFF, 1'b1, 1'b0, 1'b0);
      hold_then_ack(8'h00, 8'hFF, 6);
      repeat (2) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (8) cyc(8'h40, 8'hBF, 1'b0, 1'b0, 1'b0);
      hold_then_ack(8'h40, 8'hFF, 6);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // Overrun, clear, and clear colliding with a new overrun
      cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
      cyc(8'h08, 8'hFF, 1'b0, 1'b1, 1'b0);
      cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      hold_then_ack(8'h00, 8'hFF, 6);
      cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // Ack of id 5 coincides with a new req[5] edge
      cyc(8'h20, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h20, 8'hFF, 1'b1, 1'b0, 1'b0);
      hold_then_ack(8'h00, 8'hFF, 6);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // Reset while presenting, req[0] held through release
      cyc(8'h30, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(8'h01, 8'hFF, 1'b0, 1'b0, 1'b1);
      hold_then_ack(8'h01, 8'hFF, 6);
      repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

      // Randomised traffic
      r = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         r  = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         a  = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         co = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 199) == 0);
         cyc(r, m, a, co, rs);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/priority_irq_ctrl.md
PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 Parameter: EDGE_MODE, default 1, 1 = pending set on req rising edge, 0 = pending set while req level high.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  8  raw request lines; bit 7 highest priority, bit 0 lowest.
REQ-005 mask  input  8  per-source enable; 1 = source eligible for issue.
REQ-006 ack  input  1  consumer accepts the presented id; meaningful only while irq_valid=1.
REQ-007 clr_ovr  input  1  one-cycle pulse; clears all overrun flags.
REQ-008 irq_valid  output  1  an id is being presented.
REQ-009 irq_id  output  3  index of the presented source.
REQ-010 pending  output  8  registered pending vector (unmasked).
REQ-011 ovr  output  8  sticky per-source overrun flags.

Function
REQ-012 Block SHALL register req into req_d every cycle; edge vector = req & ~req_d (EDGE_MODE=1) or req (EDGE_MODE=0).
REQ-013 pending[i] SHALL be set at the edge where edge vector bit i = 1; the bit is visible the following cycle.
REQ-014 An edge on a source whose pending bit is already 1 SHALL set ovr[i] (EDGE_MODE=1 only); ovr[i] holds until clr_ovr or rst.
REQ-015 When clr_ovr and a new overrun hit the same bit in one cycle, the set SHALL win.
REQ-016 FSM states: IDLE, ISSUE, GAP.
REQ-017 IDLE: if (pending & mask) != 0, SHALL latch irq_id = highest set index of (pending & mask), go to ISSUE; otherwise stay.
REQ-018 ISSUE: irq_valid=1; irq_id SHALL stay stable until ack; no preemption by higher-priority arrivals or mask changes.
REQ-019 ISSUE with ack=1: SHALL clear pending[irq_id] and go to GAP.
REQ-020 GAP: irq_valid=0 for exactly one cycle, then IDLE.
REQ-021 irq_valid SHALL be 1 only in ISSUE; irq_id holds its last value outside ISSUE.
REQ-022 ack outside ISSUE SHALL be ignored.
REQ-023 If set and clear hit the same pending bit in one cycle, the set SHALL win (the new event is not lost).
REQ-024 Latency: req rises before edge k, pending set at edge k, irq_valid high after edge k+1 (2 cycles) when mask permits and FSM is in IDLE.
REQ-025 Minimum spacing between consecutive irq_valid assertions: ack cycle, then one GAP cycle, then one IDLE cycle.

Reset
REQ-026 On rst=1 at a clock edge: req_d, pending, ovr, irq_id SHALL be 0, irq_valid=0, FSM=IDLE; rst overrides all other inputs.
REQ-027 Reset mid-ISSUE SHALL drop irq_valid the next cycle and discard all pending events.
REQ-028 Because req_d resets to 0, a req bit already high on the first cycle after reset release SHALL count as a rising edge.

Structure
REQ-029 Shared package prio_pkg SHALL hold NUM_SRC=8, ID_W=3, and the FSM state encodings.
REQ-030 The highest-index search SHALL be a combinational sub-module pend_enc8 (8-bit in, 3-bit index plus any-valid out).
REQ-031 Block size target: 120-400 lines of RTL; no other sub-modules.

Verification
REQ-032 Single edge: req=0x04 rising, mask=0xFF -> irq_valid after 2 cycles, irq_id=2; ack -> pending=0x00, one GAP cycle with irq_valid=0.
REQ-033 Priority: req rises 0x81 together -> irq_id=7 first; after ack and GAP, irq_id=0; then pending=0x00.
REQ-034 No preemption and mask: bit 1 in ISSUE, req bit 6 rises -> irq_id stays 1 until ack, then 6; with mask=0xBF, bit 6 stays pending and is never issued until mask bit 6 = 1.
REQ-035 Overrun: req bit 3 pulses twice before ack -> ovr=0x08; clr_ovr -> ovr=0x00; clr_ovr in the same cycle as a third pulse -> ovr=0x08.
REQ-036 Simultaneous set and clear: ack of id 5 in the same cycle as a new req[5] edge -> pending[5] stays 1 and id 5 is reissued.
REQ-037 Reset mid-ISSUE: pending=0x30, rst for 1 cycle -> irq_valid=0, pending=0x00, ovr=0x00; req=0x01 held high through reset -> issue of id 0 after release.
